mdu_iterative: RTL and testbench
================================

// Module: mdu_iterative
// PURPOSE
//  Iterative RV32M multiply/divide unit beside the single-cycle alu in the EX stage.
//  Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. Multiply uses a shift-add loop; divide uses restoring division.
//  Each operation takes WIDTH+2 cycles, with a 1-cycle fast path for special operands.
//  Hazard unit stalls IF/ID/EX while o_busy_EX=1.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=8, even)
// PORTS
//  i_clk            in   1      clock; all state updates on rising edge
//  i_rst            in   1      synchronous, active-high reset
//  i_start_EX       in   1      start request; sampled only in IDLE
//  i_op_EX          in   3      funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  i_rd1_EX         in   WIDTH  rs1 operand (dividend / multiplicand)
//  i_rd2_EX         in   WIDTH  rs2 operand (divisor / multiplier)
//  i_flush_EX       in   1      abort current op (branch mispredict / trap)
//  o_busy_EX        out  1      op in flight (CALC or FIX)
//  o_done_EX        out  1      1-cycle pulse; o_result_EX valid this cycle
//  o_result_EX      out  WIDTH  result; held stable until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; o_busy_EX=0, o_done_EX=0, o_result_EX=0, counter=0.
//  FSM states: IDLE, CALC, FIX, DONE.
//   IDLE: i_start_EX=1 latches operands, op and sign flags.
//    - Divide with rd2==0 or signed overflow: go to DONE.
//    - Otherwise: go to CALC with cnt=WIDTH-1.
//   CALC: one iteration per cycle. At cnt==0 go to FIX, else cnt--.
//   FIX: apply sign correction (two's complement negate of quotient/remainder/product); go to DONE.
//   DONE: o_done_EX=1 for exactly one cycle. Next cycle is IDLE.
//    - A start in DONE is ignored; it must be re-presented in IDLE.
//  Latency: start accepted at edge k.
//    - Normal op: o_done_EX high in cycle after edge k+WIDTH+1.
//    - Special case: o_done_EX high in cycle after edge k.
//  o_busy_EX=1 in CALC and FIX only; IDLE and DONE drive 0.
//  Multiply: operands made absolute per signedness.
//    - MULH: both signed. MULHSU: rs1 signed, rs2 unsigned. MULHU/MUL: unsigned.
//    - 2*WIDTH-bit product accumulator.
//    - Each iteration adds the multiplicand if the multiplier LSB is set, then shifts right 1.
//    - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
//    - Product is negated when signs differ.
//  Divide: |rs1|/|rs2| restoring loop, 1 quotient bit per cycle.
//    - DIV: quotient negated if signs differ. REM: remainder takes rs1's sign.
//  Special cases (RISC-V spec, no trap):
//    - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rs1.
//    - Signed overflow (rs1=MIN, rs2=-1): DIV = MIN; REM = 0.
//  i_flush_EX=1 in any state: next state IDLE, o_done_EX=0 (even if it was due).
//    - o_result_EX keeps its last value.
//    - Flush has priority over start in the same cycle.
//  i_rst overrides flush and start.
//    - Reset mid-operation returns to IDLE within 1 cycle and clears o_result_EX.
//  Operand inputs may change after acceptance; internal copies are used.
//  No X/Z on any output in any state.
// STRUCTURE
//  Shared package (osiris_pkg): MDU op encodings MUL..REMU and FSM state typedef (2-bit).
//  One sub-module, mdu_abs_neg #(WIDTH): conditional two's complement negate.
//    - Instantiated for operand absolute values and for FIX-stage correction.
//  Datapath registers: acc[2*WIDTH-1:0], divisor, cnt[$clog2(WIDTH)-1:0], op and sign flags.
// TESTING
//  MUL 7 * -3 (0xFFFFFFFD) -> result 0xFFFFFFEB. o_done_EX exactly WIDTH+2 cycles after start; busy high throughout.
//  MULH 0x80000000 * 0x80000000 -> 0x40000000.
//  MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
//  MULHSU -1 * 2 -> 0xFFFFFFFF.
//  DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF.
//  DIVU 100 / 7 -> 14; REMU -> 2.
//  DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 % 0 -> 5: done 1 cycle after start, busy never set.
//  DIV 0x80000000 / -1 -> 0x80000000 and REM -> 0: 1-cycle path.
//  Flush at CALC cycle 10 -> no done pulse, IDLE next cycle, previous result held.
//    - Back-to-back start then completes normally.
//  Assert i_rst at CALC cycle 5 -> all outputs 0 next cycle.
//    - Start held through DONE is not re-accepted until IDLE.

Source files
------------

// File: rtl/osiris_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// funct3 operation encodings, FSM states and operand signedness helpers.
package osiris_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic op_signed_rs1(input mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM
  function automatic logic op_signed_rs2(input mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's complement negate: passes the value through, or negates it when neg is set.
// Used both to take operand magnitudes and to restore the sign of results.
module mdu_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] res
);

  // Negate is invert-plus-one; a plain pass-through when neg is clear
  always_comb begin
    res = neg ? (~val + WIDTH'(1)) : val;
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit. Multiplies by shift-add and divides by restoring
// division on operand magnitudes, one bit per cycle, then fixes up the sign in a final cycle.
// Divide-by-zero and signed overflow bypass the loop and complete in a single cycle.
module mdu_iterative
  import osiris_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start_EX,
  input  logic [2:0]       i_op_EX,
  input  logic [WIDTH-1:0] i_rd1_EX,
  input  logic [WIDTH-1:0] i_rd2_EX,
  input  logic             i_flush_EX,
  output logic             o_busy_EX,
  output logic             o_done_EX,
  output logic [WIDTH-1:0] o_result_EX
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e         state;
  mdu_op_e            op_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   divisor;
  logic [CW-1:0]      cnt;
  logic               neg_main;
  logic               neg_rem;

  mdu_op_e            op_in;
  logic               neg1_in;
  logic               neg2_in;
  logic [WIDTH-1:0]   abs1_in;
  logic [WIDTH-1:0]   abs2_in;
  logic               div_zero_in;
  logic               overflow_in;
  logic [WIDTH-1:0]   special_res;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] calc_next;

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic [WIDTH-1:0]   fix_result;

  mdu_abs_neg #(.WIDTH(WIDTH))   u_abs1 (.neg(neg1_in),  .val(i_rd1_EX),            .res(abs1_in));
  mdu_abs_neg #(.WIDTH(WIDTH))   u_abs2 (.neg(neg2_in),  .val(i_rd2_EX),            .res(abs2_in));
  mdu_abs_neg #(.WIDTH(2*WIDTH)) u_prod (.neg(neg_main), .val(acc),                 .res(prod_fixed));
  mdu_abs_neg #(.WIDTH(WIDTH))   u_quot (.neg(neg_main), .val(acc[WIDTH-1:0]),      .res(quot_fixed));
  mdu_abs_neg #(.WIDTH(WIDTH))   u_rem  (.neg(neg_rem),  .val(acc[2*WIDTH-1:WIDTH]), .res(rem_fixed));

  // Decode the incoming request: signedness, magnitudes and the single-cycle special results
  always_comb begin
    op_in       = mdu_op_e'(i_op_EX);
    neg1_in     = op_signed_rs1(op_in) & i_rd1_EX[WIDTH-1];
    neg2_in     = op_signed_rs2(op_in) & i_rd2_EX[WIDTH-1];
    div_zero_in = i_op_EX[2] && (i_rd2_EX == '0);
    overflow_in = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                  (i_rd1_EX == MIN_VAL) && (i_rd2_EX == '1);
    special_res = '0;
    if (div_zero_in) begin
      special_res = i_op_EX[1] ? i_rd1_EX : '1;
    end else if (overflow_in) begin
      special_res = i_op_EX[1] ? '0 : i_rd1_EX;
    end
  end

  // One loop iteration: shift-add step for multiply, restoring subtract step for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    rem_sh    = acc[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_sh[WIDTH-1:0] - divisor;
    if (rem_sh >= {1'b0, divisor}) begin
      div_next = {rem_diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {acc[2*WIDTH-2:0], 1'b0};
    end
    calc_next = op_q[2] ? div_next : mul_next;
  end

  // Select the sign-corrected result for the completed operation
  always_comb begin
    fix_result = '0;
    unique case (op_q)
      MDU_MUL:                        fix_result = prod_fixed[WIDTH-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_result = prod_fixed[2*WIDTH-1:WIDTH];
      MDU_DIV, MDU_DIVU:              fix_result = quot_fixed;
      MDU_REM, MDU_REMU:              fix_result = rem_fixed;
      default:                        fix_result = '0;
    endcase
  end

  // Control FSM with registered busy/done/result; reset beats flush, flush beats start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= MDU_IDLE;
      op_q        <= MDU_MUL;
      acc         <= '0;
      divisor     <= '0;
      cnt         <= '0;
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
      o_busy_EX   <= 1'b0;
      o_done_EX   <= 1'b0;
      o_result_EX <= '0;
    end else if (i_flush_EX) begin
      state     <= MDU_IDLE;
      o_busy_EX <= 1'b0;
      o_done_EX <= 1'b0;
    end else begin
      unique case (state)
        MDU_IDLE: begin
          o_busy_EX <= 1'b0;
          o_done_EX <= 1'b0;
          if (i_start_EX) begin
            op_q     <= op_in;
            neg_main <= neg1_in ^ neg2_in;
            neg_rem  <= neg1_in;
            if (i_op_EX[2]) begin
              acc     <= {{WIDTH{1'b0}}, abs1_in};
              divisor <= abs2_in;
            end else begin
              acc     <= {{WIDTH{1'b0}}, abs2_in};
              divisor <= abs1_in;
            end
            if (div_zero_in || overflow_in) begin
              o_result_EX <= special_res;
              o_done_EX   <= 1'b1;
              state       <= MDU_DONE;
            end else begin
              cnt       <= CNT_MAX;
              o_busy_EX <= 1'b1;
              state     <= MDU_CALC;
            end
          end
        end
        MDU_CALC: begin
          acc <= calc_next;
          if (cnt == '0) begin
            state <= MDU_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MDU_FIX: begin
          o_result_EX <= fix_result;
          o_busy_EX   <= 1'b0;
          o_done_EX   <= 1'b1;
          state       <= MDU_DONE;
        end
        MDU_DONE: begin
          o_done_EX <= 1'b0;
          state     <= MDU_IDLE;
        end
        default: begin
          o_busy_EX <= 1'b0;
          o_done_EX <= 1'b0;
          state     <= MDU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: a reference model fills a scoreboard queue when an
// operation is issued, and entries are popped and compared when the done pulse appears.
module tb_mdu_iterative;
  import osiris_pkg::*;

  localparam int WIDTH  = 32;
  localparam int BUDGET = WIDTH + 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              flush;
  logic [2:0]        op;
  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] res;
    int               lat;
  } exp_t;

  exp_t             sbQueue[$];
  int               assertCount = 0;
  int               failCount   = 0;
  logic [WIDTH-1:0] lastResult;

  mdu_iterative #(.WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start_EX  (start),
    .i_op_EX     (op),
    .i_rd1_EX    (rd1),
    .i_rd2_EX    (rd2),
    .i_flush_EX  (flush),
    .o_busy_EX   (busy),
    .o_done_EX   (done),
    .o_result_EX (result)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference results computed with wide native arithmetic
  function automatic logic [WIDTH-1:0] model(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    longint      sp;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    case (o)
      3'd0: begin up = {32'h0, a} * {32'h0, b}; return up[31:0]; end
      3'd1: begin sp = sa * sb; up = sp; return up[63:32]; end
      3'd2: begin sp = sa * ub; up = sp; return up[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Special operands skip the loop and finish one cycle after acceptance
  function automatic bit isSpecial(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
    return o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one operation, push its expectation, then wait for done and score it
  task automatic applyStimulus(input string name, input logic [2:0] o,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    exp_t got;
    int   cycles;
    bit   busyOk;
    e.name = name;
    e.res  = model(o, a, b);
    e.lat  = isSpecial(o, a, b) ? 1 : WIDTH + 2;
    sbQueue.push_back(e);
    @(negedge clk);
    op    = o;
    rd1   = a;
    rd2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op     = 3'($urandom);
    rd1    = $urandom;
    rd2    = $urandom;
    cycles = 1;
    busyOk = 1'b1;
    while (!done && cycles < BUDGET) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      @(posedge clk);
      #1;
      cycles++;
    end
    got = sbQueue.pop_front();
    checkOutput({got.name, " done seen"}, 32'(done), 32'd1);
    checkOutput({got.name, " latency"}, 32'(cycles), 32'(got.lat));
    checkOutput({got.name, " result"}, result, got.res);
    checkOutput({got.name, " busy while running"}, 32'(busyOk), 32'd1);
    checkOutput({got.name, " busy at done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({got.name, " done single pulse"}, 32'(done), 32'd0);
    lastResult = got.res;
  endtask

  initial begin
    int  o;
    bit  quiet;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'd0;
    rd1   = '0;
    rd2   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", result, 32'd0);
    rst = 1'b0;

    applyStimulus("MUL 7*-3",        MDU_MUL,    32'd7,          32'hFFFF_FFFD);
    applyStimulus("MULH min*min",    MDU_MULH,   32'h8000_0000,  32'h8000_0000);
    applyStimulus("MULHU max*max",   MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
    applyStimulus("MULHSU -1*2",     MDU_MULHSU, 32'hFFFF_FFFF,  32'd2);
    applyStimulus("DIV -7/2",        MDU_DIV,    32'hFFFF_FFF9,  32'd2);
    applyStimulus("REM -7%2",        MDU_REM,    32'hFFFF_FFF9,  32'd2);
    applyStimulus("DIVU 100/7",      MDU_DIVU,   32'd100,        32'd7);
    applyStimulus("REMU 100%7",      MDU_REMU,   32'd100,        32'd7);
    applyStimulus("DIVU 5/0",        MDU_DIVU,   32'd5,          32'd0);
    applyStimulus("REM 5%0",         MDU_REM,    32'd5,          32'd0);
    applyStimulus("DIV min/-1",      MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF);
    applyStimulus("REM min%-1",      MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF);
    applyStimulus("DIV 7/-7",        MDU_DIV,    32'd7,          32'hFFFF_FFF9);
    applyStimulus("REMU small/big",  MDU_REMU,   32'd3,          32'hFFFF_0000);

    for (int i = 0; i < 8; i++) begin
      o = i;
      applyStimulus($sformatf("random op%0d", i), 3'(o), $urandom, $urandom);
    end

    // Flush during CALC: no done, unit idles, previous result held
    @(negedge clk);
    op    = 3'(MDU_DIVU);
    rd1   = 32'd1000;
    rd2   = 32'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush done", 32'(done), 32'd0);
    checkOutput("flush busy", 32'(busy), 32'd0);
    checkOutput("flush result held", result, lastResult);
    quiet = 1'b1;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) quiet = 1'b0;
    end
    checkOutput("flush no late done", 32'(quiet), 32'd1);
    applyStimulus("MULHU after flush", MDU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);

    // Reset in the middle of CALC clears everything next cycle
    @(negedge clk);
    op    = 3'(MDU_MUL);
    rd1   = 32'd11;
    rd2   = 32'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset done", 32'(done), 32'd0);
    checkOutput("mid reset result", result, 32'd0);
    rst = 1'b0;

    // Start held high: ignored in DONE, re-accepted once back in IDLE
    @(negedge clk);
    op    = 3'(MDU_DIVU);
    rd1   = 32'd5;
    rd2   = 32'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("held start first done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("held start ignored in DONE", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("held start accepted in IDLE", 32'(done), 32'd1);
    start = 1'b0;
    checkOutput("held start result", result, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
